// File: rtl/pe_fork.sv
// pe_fork: duplicates one VALID/BP beat stream into two independent VALID/BP
// output streams, each buffered by its own FIFO. Upstream is throttled through
// D_BP with BP_SLACK entries of headroom kept free in both FIFOs.
module pe_fork #(
    parameter int unsigned LANES    = 8,
    parameter int unsigned W        = 64,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned BP_SLACK = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [LANES-1:0][W-1:0]   D,
    input  logic                      D_VALID,
    output logic                      D_BP,
    output logic [LANES-1:0][W-1:0]   Q1,
    output logic                      Q1_VALID,
    input  logic                      Q1_BP,
    output logic [LANES-1:0][W-1:0]   Q2,
    output logic                      Q2_VALID,
    input  logic                      Q2_BP,
    output logic                      OVF
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [LANES-1:0][W-1:0] beat_t;

    beat_t          r_mem1 [DEPTH];
    beat_t          r_mem2 [DEPTH];
    logic [AW-1:0]  r_wp1, r_rp1, r_wp2, r_rp2;
    logic [CW-1:0]  r_cnt1, r_cnt2;

    logic           w_pop1, w_pop2, w_push1, w_push2;
    logic [CW-1:0]  w_cnt1_pop, w_cnt2_pop;
    logic [CW-1:0]  w_cnt1_next, w_cnt2_next, w_cnt_max;
    logic           w_dbp_next, w_ovf_set;

    // Pop uses the pre-edge count (no bypass); fullness is judged after the pop.
    always_comb begin
        w_pop1      = !Q1_BP && (r_cnt1 != '0);
        w_pop2      = !Q2_BP && (r_cnt2 != '0);
        w_cnt1_pop  = r_cnt1 - CW'(w_pop1);
        w_cnt2_pop  = r_cnt2 - CW'(w_pop2);
        w_push1     = D_VALID && (w_cnt1_pop != CW'(DEPTH));
        w_push2     = D_VALID && (w_cnt2_pop != CW'(DEPTH));
        w_cnt1_next = w_cnt1_pop + CW'(w_push1);
        w_cnt2_next = w_cnt2_pop + CW'(w_push2);
        w_cnt_max   = (w_cnt1_next > w_cnt2_next) ? w_cnt1_next : w_cnt2_next;
        w_dbp_next  = (CW'(DEPTH) - w_cnt_max) <= CW'(BP_SLACK);
        w_ovf_set   = D_VALID && (!w_push1 || !w_push2);
    end

    // FIFO 1 storage, pointers, count and registered output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp1    <= '0;
            r_rp1    <= '0;
            r_cnt1   <= '0;
            Q1       <= '0;
            Q1_VALID <= 1'b0;
        end else begin
            if (w_push1) begin
                r_mem1[r_wp1] <= D;
                r_wp1         <= r_wp1 + AW'(1);
            end
            if (w_pop1) begin
                Q1    <= r_mem1[r_rp1];
                r_rp1 <= r_rp1 + AW'(1);
            end
            Q1_VALID <= w_pop1;
            r_cnt1   <= w_cnt1_next;
        end
    end

    // FIFO 2 storage, pointers, count and registered output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp2    <= '0;
            r_rp2    <= '0;
            r_cnt2   <= '0;
            Q2       <= '0;
            Q2_VALID <= 1'b0;
        end else begin
            if (w_push2) begin
                r_mem2[r_wp2] <= D;
                r_wp2         <= r_wp2 + AW'(1);
            end
            if (w_pop2) begin
                Q2    <= r_mem2[r_rp2];
                r_rp2 <= r_rp2 + AW'(1);
            end
            Q2_VALID <= w_pop2;
            r_cnt2   <= w_cnt2_next;
        end
    end

    // Upstream backpressure and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            D_BP <= 1'b1;
            OVF  <= 1'b0;
        end else begin
            D_BP <= w_dbp_next;
            if (w_ovf_set) begin
                OVF <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_fork.sv
// Self-checking bench for pe_fork: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based reference model.
module tb_pe_fork;

    localparam int unsigned LANES    = 8;
    localparam int unsigned W        = 64;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned BP_SLACK = 2;

    typedef logic [LANES-1:0][W-1:0] beat_t;

    logic  CLK = 1'b0;
    logic  RST;
    beat_t D;
    logic  D_VALID;
    logic  D_BP;
    beat_t Q1, Q2;
    logic  Q1_VALID, Q2_VALID;
    logic  Q1_BP, Q2_BP;
    logic  OVF;

    pe_fork #(
        .LANES    (LANES),
        .W        (W),
        .DEPTH    (DEPTH),
        .BP_SLACK (BP_SLACK)
    ) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .D        (D),
        .D_VALID  (D_VALID),
        .D_BP     (D_BP),
        .Q1       (Q1),
        .Q1_VALID (Q1_VALID),
        .Q1_BP    (Q1_BP),
        .Q2       (Q2),
        .Q2_VALID (Q2_VALID),
        .Q2_BP    (Q2_BP),
        .OVF      (OVF)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: two queues plus expected registered outputs.
    beat_t mq1[$];
    beat_t mq2[$];
    beat_t exp_q1, exp_q2;
    logic  exp_v1, exp_v2, exp_dbp, exp_ovf;
    int    n_rx1, n_rx2;

    task automatic check(input string tag, input logic [LANES*W-1:0] got,
                         input logic [LANES*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input logic [W-1:0] v);
        beat_t b;
        b    = '0;
        b[0] = v;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        for (int i = 0; i < LANES; i++) begin
            b[i] = {$urandom(), $urandom()};
        end
        return b;
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic rst, input logic dv, input beat_t d,
                        input logic b1, input logic b2);
        int mx;
        RST     = rst;
        D_VALID = dv;
        D       = d;
        Q1_BP   = b1;
        Q2_BP   = b2;
        if (rst) begin
            mq1.delete();
            mq2.delete();
            exp_q1  = '0;
            exp_q2  = '0;
            exp_v1  = 1'b0;
            exp_v2  = 1'b0;
            exp_ovf = 1'b0;
            exp_dbp = 1'b1;
        end else begin
            exp_v1 = !b1 && (mq1.size() > 0);
            if (exp_v1) exp_q1 = mq1.pop_front();
            exp_v2 = !b2 && (mq2.size() > 0);
            if (exp_v2) exp_q2 = mq2.pop_front();
            if (dv) begin
                if (mq1.size() < DEPTH) mq1.push_back(d);
                else exp_ovf = 1'b1;
                if (mq2.size() < DEPTH) mq2.push_back(d);
                else exp_ovf = 1'b1;
            end
            mx = (mq1.size() > mq2.size()) ? mq1.size() : mq2.size();
            exp_dbp = (int'(DEPTH) - mx) <= int'(BP_SLACK);
        end
        @(posedge CLK);
        #1;
        check("q1_valid", Q1_VALID, exp_v1);
        check("q2_valid", Q2_VALID, exp_v2);
        check("q1_data", Q1, exp_q1);
        check("q2_data", Q2, exp_q2);
        check("d_bp", D_BP, exp_dbp);
        check("ovf", OVF, exp_ovf);
        if (Q1_VALID) n_rx1++;
        if (Q2_VALID) n_rx2++;
    endtask

    task automatic idle(input int n, input logic b1, input logic b2);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, b1, b2);
    endtask

    initial begin
        int   extra;
        int   sent;
        logic snd;
        RST = 1'b1; D = '0; D_VALID = 1'b0; Q1_BP = 1'b0; Q2_BP = 1'b0;

        // Reset, with a beat presented that must be discarded.
        step(1'b1, 1'b1, mk(64'h dead), 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Single beat.
        step(1'b0, 1'b1, mk(64'h1111), 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Back-to-back beats.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, mk(64'(i * 'h1111)), 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);

        // Output 1 throttled for 10 cycles starting with the first beat.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i < 4, (i < 4) ? mk(64'((i + 1) * 'h1111)) : '0, 1'b1, 1'b0);
        end
        idle(6, 1'b0, 1'b0);

        // Both throttled, compliant upstream.
        extra = 0;
        sent  = 0;
        for (int i = 0; i < 12; i++) begin
            snd = 1'b0;
            if (!exp_dbp) snd = 1'b1;
            else if (extra == 0) begin snd = 1'b1; extra = 1; end
            step(1'b0, snd, mk(64'(150 + sent)), 1'b1, 1'b1);
            if (snd) sent++;
        end
        n_rx1 = 0; n_rx2 = 0;
        idle(10, 1'b0, 1'b0);
        check("compliant_rx1", 32'(n_rx1), 32'd7);
        check("compliant_rx2", 32'(n_rx2), 32'd7);

        // Overflow: 12 beats ignoring D_BP.
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, mk(64'(i)), 1'b1, 1'b1);
        n_rx1 = 0; n_rx2 = 0;
        idle(12, 1'b0, 1'b0);
        check("ovf_rx1", 32'(n_rx1), 32'd8);
        check("ovf_rx2", 32'(n_rx2), 32'd8);
        check("ovf_sticky", OVF, 1'b1);

        // Reset mid-operation.
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, mk(64'(i + 'h70)), 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        n_rx1 = 0; n_rx2 = 0;
        idle(6, 1'b0, 1'b0);
        check("post_reset_rx1", 32'(n_rx1), 32'd0);
        step(1'b0, 1'b1, mk(64'h5a5a), 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);

        // Randomized phase: compliant upstream, random consumer throttling.
        extra = 0;
        for (int i = 0; i < 400; i++) begin
            snd = 1'b0;
            if (!exp_dbp) begin
                extra = 0;
                snd   = 1'($urandom_range(0, 3) != 0);
            end else if (extra == 0) begin
                snd = 1'($urandom_range(0, 1));
                if (snd) extra = 1;
            end
            step(1'b0, snd, rnd_beat(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0));
        end
        idle(12, 1'b0, 1'b0);
        check("random_no_ovf", OVF, 1'b0);

        // Random overflow stress with uncompliant upstream.
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), rnd_beat(),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        end
        idle(12, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_fork.md
# pe_fork

Stream duplicator for the PE datapath: accepts one 8-lane × 64-bit VALID/BP stream and delivers every beat, in order, to two independent VALID/BP output streams. It is the fan-out counterpart of the two-input PE join blocks (e.g. `pe_add`). Each output has its own FIFO, so one slow consumer does not stall the other until its FIFO nears full. Upstream is then throttled through `D_BP`.

## Interface
- `LANES`, 8: lanes per beat
- `W`, 64: bits per lane
- `DEPTH`, 8: entries per output FIFO; power of two, ≥ `BP_SLACK`+2
- `BP_SLACK`, 2: free entries reserved for beats in flight after `D_BP` rises

- `CLK`  in  1: clock, all logic on posedge
- `RST`  in  1: reset, synchronous, active-high
- `D`  in  [LANES-1:0][W-1:0]: input beat
- `D_VALID`  in  1: `D` carries a beat this cycle
- `D_BP`  out  1: backpressure to upstream, registered
- `Q1`, `Q2`  out  [LANES-1:0][W-1:0]: output beats, registered
- `Q1_VALID`, `Q2_VALID`  out  1: output beat valid, registered
- `Q1_BP`, `Q2_BP`  in  1: backpressure from each consumer
- `OVF`  out  1: sticky overflow flag

## Operation
- **Protocol.** A beat transfers on every posedge where VALID=1. There is no ready qualifier. BP is a throttle with slack; no acceptance is implied.
- **Push.** At each posedge with `D_VALID`=1, the beat is written to both FIFOs.
- **Pop, per output n independently.** At each posedge:
  - If `Qn_BP` (sampled) = 0 and FIFO n is not empty: `Qn` ← head, `Qn_VALID` ← 1, pop.
  - Otherwise `Qn_VALID` ← 0 and `Qn` holds its previous value.
- **Full check.** Fullness is evaluated after the same-edge pop. A push into a full FIFO that pops on the same edge is accepted, and the count stays at `DEPTH`.
- **Overflow.**
  - A push into a FIFO that is full after pop is dropped for that FIFO only. The other FIFO still accepts the beat.
  - `OVF` ← 1 and stays set until `RST`.
  - The FIFO contents, order and count of the full FIFO are not disturbed.
- **D_BP.**
  - `D_BP` ← 1 if `DEPTH` − max(cnt1_next, cnt2_next) ≤ `BP_SLACK`; otherwise 0.
  - cntn_next is the count after this edge's push and pop.
  - With the defaults, `D_BP` rises when either count reaches 6.
- **Upstream contract.** After `D_BP` rises, upstream may deliver at most one further beat. A compliant upstream never causes `OVF`.
- **Counts.** Each count is log2(`DEPTH`)+1 bits, covering 0..`DEPTH`. Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
- **Data path.** The block performs no arithmetic on data. Beats are bit-exact copies, and ordering is preserved per output.

## Timing
- **Reset, while `RST`=1 at a posedge:**
  - `Q1_VALID` = `Q2_VALID` = 0.
  - `Q1` = `Q2` = 0.
  - Both counts and all pointers = 0.
  - `OVF` = 0.
  - `D_BP` = 1.
- **Leaving reset.** On the first edge with `RST`=0, `D_BP` is recomputed and becomes 0. Beats presented while `RST`=1 are discarded.
- **Reset mid-operation.** All queued beats are discarded. No stale beat appears on `Q1`/`Q2` after `RST` is released.
- **Latency.** A beat sampled at edge k appears on `Qn` with `Qn_VALID`=1 from edge k+1, provided FIFO n was empty and `Qn_BP`=0. The FIFO has no bypass.
- **Throughput.** One beat per cycle per output when unthrottled.
- **Output stop.** After `Qn_BP` rises, the block launches at most one more beat on output n, then none until `Qn_BP` is sampled 0. Resumption is on the first edge `Qn_BP`=0 is sampled.
- **Simultaneous push and pop on an empty FIFO.** The pop sees the pre-edge empty state, so there is no pop. The beat is written and pops on the next edge.

## Test plan
1. **Single beat.** `D[0]`=1111 with `D_VALID` for one cycle at edge k → `Q1[0]`=`Q2[0]`=1111 with `Q1_VALID`=`Q2_VALID`=1 for exactly the cycle after edge k+1. `OVF`=0.
2. **Back-to-back beats.** `D[0]` = 1111, 2222, 3333, 4444 on consecutive cycles, no BP → both outputs show 1111..4444 on four consecutive cycles starting one cycle after the first input. `D_BP` stays 0.
3. **One consumer throttled.** `Q1_BP`=1 for 10 cycles starting at the first beat, then the 4 beats of test 2 →
   - `Q2` drains immediately.
   - `Q1` emits at most one beat while BP is high, then the rest in order after release.
   - `D_BP` stays 0 (max count 4 < 6).
4. **Both consumers throttled, compliant upstream.** `Q1_BP`=`Q2_BP`=1; upstream streams 150, 151, … and stops one beat after seeing `D_BP` →
   - `D_BP` rises when count = 6.
   - Exactly 7 beats are accepted.
   - After release, both outputs deliver 150..156 in order.
   - `OVF`=0.
5. **Overflow.** Both BP held; upstream ignores `D_BP` and sends 12 beats (1..12) →
   - Beats 9..12 are dropped and `OVF`=1 stays set.
   - After release, each output emits exactly 1..8.
6. **Reset mid-operation.** 3 beats queued with `Q1_BP`=1, then `RST` pulsed for one cycle →
   - The next edge shows VALIDs=0, `D_BP`=1, `OVF`=0.
   - After release, no beat is emitted until new input arrives.
